// File: rtl/l2_tlb_pkg.sv
// Shared L2 TLB replacement definitions: way count, PLRU tree width,
// sweep FSM encodings and the 4-way tree-PLRU touch rule.
package l2_tlb_pkg;

  localparam int L2_WAYS = 4;
  localparam int PLRU_W  = 4;
  localparam int WAY_W   = $clog2(L2_WAYS);

  localparam logic [0:0] PLRU_IDLE  = 1'b0;
  localparam logic [0:0] PLRU_SWEEP = 1'b1;

  // Tree layout is {n3, n2, n1, 1'b0}; victim way = {n1, n(2+n1)}.
  // A touch points every node on the path away from the touched way.
  function automatic logic [PLRU_W-1:0] plru_touch(
    input logic [PLRU_W-1:0] tree,
    input logic [WAY_W-1:0]  way
  );
    logic [PLRU_W-1:0] t;
    t    = tree;
    t[1] = ~way[1];
    if (way[1]) begin
      t[3] = ~way[0];
    end else begin
      t[2] = ~way[0];
    end
    t[0] = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/plru_tree4_next.sv
// Combinational 4-way tree-PLRU touch update, reusable by any 4-way structure.
// Zero latency; no flow control.
module plru_tree4_next
  import l2_tlb_pkg::*;
(
  input  logic [PLRU_W-1:0] tree_i,
  input  logic [WAY_W-1:0]  way_i,
  output logic [PLRU_W-1:0] tree_o
);

  assign tree_o = plru_touch(tree_i, way_i);

endmodule

// File: rtl/l2_tlb_plru_update.sv
// Per-set tree-PLRU keeper for the 4-way L2 TLB: applies touches, serves a set's
// tree one cycle after lookup, and clears every set with an NSETS-cycle sweep.
module l2_tlb_plru_update
  import l2_tlb_pkg::*;
#(
  parameter int NSETS = 32,
  parameter int IDX_W = 5
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic [3:0]       L2_plru_val,
  input  logic             touch_valid,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [1:0]       touch_way,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done
);

  // One extra counter bit so the terminal compare never aliases with set 0.
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(NSETS - 1);

  logic [NSETS-1:0]  n1_q, n1_d;
  logic [NSETS-1:0]  n2_q, n2_d;
  logic [NSETS-1:0]  n3_q, n3_d;
  logic [0:0]        state_q, state_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic [PLRU_W-1:0] plru_val_q, plru_val_d;

  logic              busy;
  logic              sweep_last;
  logic [IDX_W-1:0]  sweep_idx;
  logic              bypass_hit;
  logic [PLRU_W-1:0] touch_tree_cur;
  logic [PLRU_W-1:0] touch_tree_nxt;
  logic [PLRU_W-1:0] lookup_tree;

  assign busy       = (state_q == PLRU_SWEEP);
  assign sweep_last = (cnt_q == CNT_LAST);
  assign sweep_idx  = cnt_q[IDX_W-1:0];
  assign bypass_hit = touch_valid && (touch_idx == lookup_idx);

  assign touch_tree_cur = {n3_q[touch_idx], n2_q[touch_idx], n1_q[touch_idx], 1'b0};
  assign lookup_tree    = {n3_q[lookup_idx], n2_q[lookup_idx], n1_q[lookup_idx], 1'b0};

  plru_tree4_next u_tree_next (
    .tree_i (touch_tree_cur),
    .way_i  (touch_way),
    .tree_o (touch_tree_nxt)
  );

  always_comb begin
    n1_d       = n1_q;
    n2_d       = n2_q;
    n3_d       = n3_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    plru_val_d = plru_val_q;

    case (state_q)
      PLRU_IDLE: begin
        if (touch_valid) begin
          n1_d[touch_idx] = touch_tree_nxt[1];
          n2_d[touch_idx] = touch_tree_nxt[2];
          n3_d[touch_idx] = touch_tree_nxt[3];
        end
        if (flush_req) begin
          state_d = PLRU_SWEEP;
          cnt_d   = '0;
        end
      end
      PLRU_SWEEP: begin
        n1_d[sweep_idx] = 1'b0;
        n2_d[sweep_idx] = 1'b0;
        n3_d[sweep_idx] = 1'b0;
        if (sweep_last) begin
          state_d = PLRU_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = PLRU_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Mid-sweep the TLB holds nothing valid, so way 0 is a safe answer.
    if (lookup_valid) begin
      if (busy) begin
        plru_val_d = '0;
      end else if (bypass_hit) begin
        plru_val_d = touch_tree_nxt;
      end else begin
        plru_val_d = lookup_tree;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n1_q       <= '0;
      n2_q       <= '0;
      n3_q       <= '0;
      state_q    <= PLRU_IDLE;
      cnt_q      <= '0;
      plru_val_q <= '0;
    end else begin
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      n3_q       <= n3_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      plru_val_q <= plru_val_d;
    end
  end

  assign L2_plru_val = plru_val_q;
  assign flush_busy  = busy;
  assign flush_done  = busy && sweep_last;

endmodule
